data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-port responder for a single-cycle core: word RAM, console byte FIFO,
// status register, free-running 64-bit cycle counter and a sticky error flag.
// Loads are combinational; all state updates on the rising edge of clk.
module data_mem_responder #(
   parameter int RAM_WORDS = 1024,
   parameter int TXQ_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_ready_i,
   output logic        err_o
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int QW = $clog2(TXQ_DEPTH);

   localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
   localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
   localparam logic [31:0] ADDR_CYC_LO = 32'hFFFF_0008;
   localparam logic [31:0] ADDR_CYC_HI = 32'hFFFF_000C;

   logic [31:0]   mem [RAM_WORDS];
   logic [7:0]    fifo_q [TXQ_DEPTH];

   logic [QW-1:0] rptr_q, rptr_d;
   logic [QW-1:0] wptr_q, wptr_d;
   logic [QW:0]   cnt_q, cnt_d;
   logic [63:0]   cyc_q, cyc_d;
   logic          err_q, err_d;

   logic          hit_ram, hit_tx, hit_st, hit_lo, hit_hi, hit_none;
   logic [AW-1:0] ram_idx;
   logic          acc, wr, rd;
   logic          full, empty;
   logic          pop, push_req, push, drop;
   logic [31:0]   status;

   // Address decode; the RAM window is the low RAM_WORDS*4 bytes.
   always_comb begin
      hit_ram  = (addr_i >> (AW + 2)) == 32'd0;
      hit_tx   = addr_i == ADDR_TXDATA;
      hit_st   = addr_i == ADDR_STATUS;
      hit_lo   = addr_i == ADDR_CYC_LO;
      hit_hi   = addr_i == ADDR_CYC_HI;
      hit_none = !(hit_ram || hit_tx || hit_st || hit_lo || hit_hi);
      ram_idx  = addr_i[AW+1:2];
      // Core accesses are ignored entirely while reset is held.
      acc      = rst && ce_i;
      wr       = acc && we_i;
      rd       = acc && !we_i;
   end

   // FIFO handshake: a full FIFO still accepts a push when the head leaves in the same edge.
   always_comb begin
      full     = cnt_q == (QW+1)'(TXQ_DEPTH);
      empty    = cnt_q == '0;
      pop      = !empty && tx_ready_i;
      push_req = wr && hit_tx;
      push     = push_req && (!full || pop);
      drop     = push_req && full && !pop;
   end

   // Next-state for pointers, occupancy, error flag and cycle counter.
   always_comb begin
      rptr_d = pop  ? rptr_q + QW'(1) : rptr_q;
      wptr_d = push ? wptr_q + QW'(1) : wptr_q;
      cnt_d  = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + (QW+1)'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - (QW+1)'(1);
      end
      err_d = err_q || (acc && (hit_none || (we_i && hit_st))) || drop;
      cyc_d = (wr && hit_lo) ? 64'd0 : cyc_q + 64'd1;
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
         cyc_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         cyc_q  <= cyc_d;
         err_q  <= err_d;
      end
   end

   // RAM store; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr && hit_ram) begin
         mem[ram_idx] <= wdata_i;
      end
   end

   // FIFO storage write; push is already gated by reset through acc.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wptr_q] <= wdata_i[7:0];
      end
   end

   // Load mux; TXDATA, unmapped and non-read cycles return zero.
   always_comb begin
      status  = {16'h0000, 8'(cnt_q), 5'b00000, err_q, empty, full};
      rdata_o = 32'h0;
      if (rd) begin
         if (hit_ram) begin
            rdata_o = mem[ram_idx];
         end else if (hit_st) begin
            rdata_o = status;
         end else if (hit_lo) begin
            rdata_o = cyc_q[31:0];
         end else if (hit_hi) begin
            rdata_o = cyc_q[63:32];
         end
      end
   end

   // Console outputs; the head only moves on a pop, so data is stable while stalled.
   always_comb begin
      tx_valid_o = !empty;
      tx_data_o  = empty ? 8'h00 : fifo_q[rptr_q];
      err_o      = err_q;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vectors with literal expectations,
// plus a queue/array model compared against the outputs every cycle.
module tb_data_mem_responder;

   localparam int RAM_WORDS = 1024;
   localparam int TXQ_DEPTH = 8;

   localparam logic [31:0] A_TX = 32'hFFFF_0000;
   localparam logic [31:0] A_ST = 32'hFFFF_0004;
   localparam logic [31:0] A_LO = 32'hFFFF_0008;
   localparam logic [31:0] A_HI = 32'hFFFF_000C;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_ready_i;
   logic        err_o;

   int n_vec = 0;
   int n_err = 0;

   data_mem_responder #(.RAM_WORDS(RAM_WORDS), .TXQ_DEPTH(TXQ_DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce_i      (ce_i),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .rdata_o   (rdata_o),
      .tx_valid_o(tx_valid_o),
      .tx_data_o (tx_data_o),
      .tx_ready_i(tx_ready_i),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [31:0] ram_m [int];
   logic [7:0]  q_m [$];
   logic [63:0] cyc_m;
   logic        err_m;
   bit          model_ok = 0;

   // 0 ram, 1 txdata, 2 status, 3 cyc_lo, 4 cyc_hi, 5 unmapped
   function automatic int region(input logic [31:0] a);
      if (64'(a) < 64'(RAM_WORDS) * 4) return 0;
      if (a == A_TX) return 1;
      if (a == A_ST) return 2;
      if (a == A_LO) return 3;
      if (a == A_HI) return 4;
      return 5;
   endfunction

   always begin
      @(negedge clk);
      if (model_ok) begin
         int r;
         int idx;
         logic [31:0] exp_rd;
         bit do_rd;
         r      = region(addr_i);
         idx    = int'(addr_i / 4);
         do_rd  = 1;
         exp_rd = 32'h0;
         if (!rst && ce_i) begin
            do_rd = 0;
         end else if (rst && ce_i && !we_i) begin
            case (r)
               0: if (ram_m.exists(idx)) exp_rd = ram_m[idx]; else do_rd = 0;
               2: exp_rd = {16'h0, 8'(q_m.size()), 5'b0, err_m,
                            q_m.size() == 0, q_m.size() == TXQ_DEPTH};
               3: exp_rd = cyc_m[31:0];
               4: exp_rd = cyc_m[63:32];
               default: exp_rd = 32'h0;
            endcase
         end
         if (do_rd) chk("model rdata", 64'(rdata_o), 64'(exp_rd));
         chk("model tx_valid", 64'(tx_valid_o), 64'(q_m.size() != 0));
         if (q_m.size() != 0) chk("model tx_data", 64'(tx_data_o), 64'(q_m[0]));
         chk("model err", 64'(err_o), 64'(err_m));
      end
      @(posedge clk);
      if (!rst) begin
         q_m.delete();
         cyc_m    = 64'd0;
         err_m    = 1'b0;
         model_ok = 1;
      end else if (model_ok) begin
         bit popm, pushm, clr;
         int r;
         popm  = q_m.size() != 0 && tx_ready_i;
         pushm = 0;
         clr   = 0;
         r     = region(addr_i);
         if (ce_i) begin
            if (r == 5) err_m = 1'b1;
            if (we_i) begin
               case (r)
                  0: ram_m[int'(addr_i / 4)] = wdata_i;
                  1: if (q_m.size() < TXQ_DEPTH || popm) pushm = 1; else err_m = 1'b1;
                  2: err_m = 1'b1;
                  3: clr = 1;
                  default: ;
               endcase
            end
         end
         if (popm) void'(q_m.pop_front());
         if (pushm) q_m.push_back(wdata_i[7:0]);
         cyc_m = clr ? 64'd0 : cyc_m + 64'd1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic op(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
      ce_i = c; we_i = w; addr_i = a; wdata_i = d;
      #2;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      op(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic reset_pulse;
      rst = 1'b0;
      idle();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; tx_ready_i = 1'b0;
      tick(); tick();
      #2;
      chk("reset tx_valid", 64'(tx_valid_o), 64'd0);
      chk("reset tx_data", 64'(tx_data_o), 64'd0);
      chk("reset err", 64'(err_o), 64'd0);
      chk("reset rdata", 64'(rdata_o), 64'd0);
      tick();
      rst = 1'b1;
      #2;
      chk("post-reset tx_valid", 64'(tx_valid_o), 64'd0);
      chk("post-reset err", 64'(err_o), 64'd0);

      // RAM write then aliased read
      op(1, 1, 32'h10, 32'hDEADBEEF); tick();
      op(1, 0, 32'h12, 32'h0);
      chk("ram read 0x12", 64'(rdata_o), 64'hDEADBEEF);
      tick();
      // last RAM word and first address beyond RAM
      op(1, 1, 32'hFFC, 32'h1234_5678); tick();
      op(1, 0, 32'hFFF, 32'h0);
      chk("ram last word", 64'(rdata_o), 64'h1234_5678);
      tick();
      op(1, 0, A_TX, 32'h0);
      chk("txdata read zero", 64'(rdata_o), 64'd0);
      tick();
      op(1, 1, 32'h10, 32'h0);
      chk("write cycle rdata zero", 64'(rdata_o), 64'd0);
      tick();
      op(1, 1, 32'h10, 32'hDEADBEEF); tick();

      // fill past full with sink stalled
      tx_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         op(1, 1, A_TX, 32'h41 + i); tick();
      end
      op(1, 0, A_ST, 32'h0);
      chk("status full+err", 64'(rdata_o), 64'h805);
      tick();
      idle();
      chk("stalled head", 64'(tx_data_o), 64'h41);
      tick();
      chk("stalled head stable", 64'(tx_data_o), 64'h41);
      tx_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #0;
         chk("drain order", 64'(tx_data_o), 64'(8'h41 + i));
         tick();
      end
      #2;
      chk("drained valid", 64'(tx_valid_o), 64'd0);
      tx_ready_i = 1'b0;

      // push while full with simultaneous pop
      reset_pulse();
      for (int i = 0; i < 8; i++) begin
         op(1, 1, A_TX, 32'h41 + i); tick();
      end
      tx_ready_i = 1'b1;
      op(1, 1, A_TX, 32'h5A); tick();
      tx_ready_i = 1'b0;
      op(1, 0, A_ST, 32'h0);
      chk("status full no err", 64'(rdata_o), 64'h801);
      chk("err after full push+pop", 64'(err_o), 64'd0);
      tick();
      idle();
      tx_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #0;
         chk("drain after swap", 64'(tx_data_o), (i == 7) ? 64'h5A : 64'(8'h42 + i));
         tick();
      end
      tx_ready_i = 1'b0;

      // empty FIFO, push: no same-cycle pop
      tx_ready_i = 1'b1;
      op(1, 1, A_TX, 32'h77);
      chk("empty push no valid", 64'(tx_valid_o), 64'd0);
      tick();
      idle();
      chk("count one head", 64'(tx_data_o), 64'h77);
      tick();
      tx_ready_i = 1'b0;

      // cycle counter: counter reads k after k edges out of reset
      reset_pulse();
      idle();
      repeat (100) tick();
      op(1, 0, A_LO, 32'h0);
      chk("cyc_lo after 100", 64'(rdata_o), 64'd100);
      tick();
      op(1, 0, A_HI, 32'h0);
      chk("cyc_hi", 64'(rdata_o), 64'd0);
      tick();
      op(1, 1, A_HI, 32'hFFFF_FFFF); tick();
      op(1, 1, A_LO, 32'h1); tick();
      op(1, 0, A_LO, 32'h0);
      chk("cyc_lo after clear", 64'(rdata_o), 64'd0);
      tick();
      op(1, 0, A_LO, 32'h0);
      chk("cyc_lo counts again", 64'(rdata_o), 64'd1);
      tick();

      // unmapped read sets err; reset clears it but keeps RAM
      op(1, 0, 32'h8000_0000, 32'h0);
      chk("unmapped rdata", 64'(rdata_o), 64'd0);
      chk("err before edge", 64'(err_o), 64'd0);
      tick();
      idle();
      chk("err sticky set", 64'(err_o), 64'd1);
      tick();
      chk("err still set", 64'(err_o), 64'd1);
      reset_pulse();
      #2;
      chk("err cleared", 64'(err_o), 64'd0);
      chk("fifo empty after reset", 64'(tx_valid_o), 64'd0);
      op(1, 0, 32'h10, 32'h0);
      chk("ram kept over reset", 64'(rdata_o), 64'hDEADBEEF);
      tick();
      op(1, 0, A_ST, 32'h0);
      chk("status after reset", 64'(rdata_o), 64'h2);
      tick();
      op(1, 0, 32'h1000, 32'h0); tick();
      idle();
      chk("ram end+1 unmapped", 64'(err_o), 64'd1);
      reset_pulse();
      op(1, 1, A_ST, 32'h0); tick();
      idle();
      chk("status write err", 64'(err_o), 64'd1);
      reset_pulse();

      // mixed traffic checked by the model
      for (int i = 0; i < 300; i++) begin
         int sel;
         logic [31:0] a;
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1, 2: a = 32'(4 * $urandom_range(0, 7) + $urandom_range(0, 3));
            3, 4, 5: a = A_TX;
            6:       a = A_ST;
            7:       a = A_LO;
            8:       a = A_HI;
            default: a = ($urandom_range(0, 15) == 0) ? 32'h0001_0000 : A_ST;
         endcase
         tx_ready_i = ($urandom_range(0, 2) == 0);
         op(($urandom_range(0, 4) != 0), ($urandom_range(0, 1) == 1) && !(sel >= 6 && sel != 7), a, $urandom);
         tick();
      end
      idle();
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
